dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: serialises CPU MEM-stage and debug-port accesses onto a
// single fixed-latency memory port, CPU first with a bounded debug-starvation limit.
module dmem_arbiter #(
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   output logic [31:0] cpu_rdata_o,
   output logic        cpu_done_o,
   output logic        stall_o,
   input  logic        dbg_req_i,
   input  logic        dbg_we_i,
   input  logic [31:0] dbg_addr_i,
   input  logic [31:0] dbg_wdata_i,
   output logic        dbg_gnt_o,
   output logic [31:0] dbg_rdata_o,
   output logic        dbg_valid_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
   typedef enum logic {OWN_CPU, OWN_DBG} owner_e;

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic [CW-1:0]   lat_q, lat_d;
   logic [CW-1:0]   starve_q, starve_d;
   logic            op_we_q, op_we_d;
   logic [DW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic            cpu_done_q, cpu_done_d;
   logic            dbg_valid_q, dbg_valid_d;
   logic            dbg_gnt_q, dbg_gnt_d;
   logic            dbg_wins;

   // Next-state, grant and capture logic
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      op_we_d     = op_we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      cpu_done_d  = 1'b0;
      dbg_valid_d = 1'b0;
      dbg_gnt_d   = dbg_gnt_q;
      dbg_wins    = dbg_req_i && (!cpu_req_i || (starve_q == CW'(STARVE_MAX)));

      case (state_q)
         S_IDLE: begin
            if (cpu_req_i || dbg_req_i) begin
               state_d  = S_ISSUE;
               mem_en_d = 1'b1;
               if (dbg_wins) begin
                  owner_d   = OWN_DBG;
                  op_we_d   = dbg_we_i;
                  addr_d    = dbg_addr_i;
                  wdata_d   = dbg_wdata_i;
                  mem_we_d  = dbg_we_i;
                  starve_d  = '0;
                  dbg_gnt_d = 1'b1;
               end else begin
                  owner_d   = OWN_CPU;
                  op_we_d   = cpu_we_i;
                  addr_d    = cpu_addr_i;
                  wdata_d   = cpu_wdata_i;
                  mem_we_d  = cpu_we_i;
                  dbg_gnt_d = 1'b0;
                  // a CPU win with debug waiting implies starve_q < STARVE_MAX
                  if (dbg_req_i) starve_d = starve_q + CW'(1);
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            lat_d   = CW'(MEM_LAT);
         end
         S_WAIT: begin
            if (lat_q == CW'(1)) begin
               state_d     = S_RESP;
               cpu_done_d  = (owner_q == OWN_CPU);
               dbg_valid_d = (owner_q == OWN_DBG);
               if (!op_we_q) begin
                  if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata_i;
                  else                    dbg_rdata_d = mem_rdata_i;
               end
            end else begin
               lat_d = lat_q - CW'(1);
            end
         end
         S_RESP: begin
            state_d   = S_IDLE;
            dbg_gnt_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_CPU;
         lat_q       <= '0;
         starve_q    <= '0;
         op_we_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         cpu_done_q  <= 1'b0;
         dbg_valid_q <= 1'b0;
         dbg_gnt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         op_we_q     <= op_we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         cpu_done_q  <= cpu_done_d;
         dbg_valid_q <= dbg_valid_d;
         dbg_gnt_q   <= dbg_gnt_d;
      end
   end

   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign cpu_rdata_o = cpu_rdata_q;
   assign cpu_done_o  = cpu_done_q;
   assign dbg_rdata_o = dbg_rdata_q;
   assign dbg_valid_o = dbg_valid_q;
   assign dbg_gnt_o   = dbg_gnt_q;
   // pipeline freeze must drop in the same cycle the done pulse appears
   assign stall_o     = cpu_req_i & ~cpu_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: requesters and a fixed-latency memory are
// modelled here; a transaction-level scoreboard predicts every pulse and access.
module tb_dmem_arbiter;
   localparam int MEM_LAT    = 3;
   localparam int STARVE_MAX = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
   logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i, mem_rdata_i;
   logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o;
   logic        cpu_done_o, stall_o, dbg_gnt_o, dbg_valid_o, mem_en_o, mem_we_o;

   dmem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_done_o(cpu_done_o),
      .stall_o(stall_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
      .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rdata_o(dbg_rdata_o),
      .dbg_valid_o(dbg_valid_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          issue;
      int          done;
      bit          dbg;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem[16];
   logic [31:0] dev_mem[16];
   logic [31:0] m_cpu_rdata = '0, m_dbg_rdata = '0;
   logic [31:0] dev_data = '0;
   int          dev_due = -1;
   int          cyc = 0, free_cyc = 0, starve = 0;
   int          vectors = 0, miscompares = 0;
   bit          rst_prev = 1'b0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor, memory device and reference model, all on the falling edge
   always @(negedge clk_i) begin
      exp_t cur;
      exp_t e;
      bit   have, e_en, e_cpu, e_dbg, e_gnt, pick_dbg;
      have  = (exp_q.size() > 0);
      if (have) cur = exp_q[0];
      e_en  = have && (cur.issue == cyc);
      e_cpu = have && (cur.done == cyc) && !cur.dbg;
      e_dbg = have && (cur.done == cyc) && cur.dbg;
      e_gnt = have && cur.dbg && (cyc >= cur.issue) && (cyc <= cur.done);

      if (rst_prev) begin
         chk32("rst_mem_addr", mem_addr_o, 32'h0);
         chk32("rst_mem_wdata", mem_wdata_o, 32'h0);
      end
      chk1("mem_en", mem_en_o, e_en);
      if (e_en) begin
         chk1("mem_we", mem_we_o, cur.we);
         chk32("mem_addr", mem_addr_o, cur.addr);
         if (cur.we) chk32("mem_wdata", mem_wdata_o, cur.wdata);
      end else begin
         chk1("mem_we_idle", mem_we_o, 1'b0);
      end
      chk1("cpu_done", cpu_done_o, e_cpu);
      chk1("dbg_valid", dbg_valid_o, e_dbg);
      chk1("dbg_gnt", dbg_gnt_o, e_gnt);
      chk1("stall", stall_o, cpu_req_i & ~e_cpu);
      if (have && (cur.done == cyc)) begin
         if (!cur.we) begin
            if (cur.dbg) m_dbg_rdata = cur.rdata;
            else         m_cpu_rdata = cur.rdata;
         end
         void'(exp_q.pop_front());
      end
      chk32("cpu_rdata", cpu_rdata_o, m_cpu_rdata);
      chk32("dbg_rdata", dbg_rdata_o, m_dbg_rdata);

      // memory device: data valid exactly MEM_LAT cycles after the enable, noise otherwise
      if (mem_en_o === 1'b1) begin
         if (mem_we_o) dev_mem[mem_addr_o[5:2]] = mem_wdata_o;
         else begin
            dev_due  = cyc + MEM_LAT;
            dev_data = dev_mem[mem_addr_o[5:2]];
         end
      end
      mem_rdata_i = (cyc == dev_due) ? dev_data : $urandom;

      // reference model: one operation per 3+MEM_LAT cycles, accepted when free
      if (!rst_i) begin
         exp_q.delete();
         starve      = 0;
         m_cpu_rdata = '0;
         m_dbg_rdata = '0;
         free_cyc    = cyc + 1;
      end else if ((cyc >= free_cyc) && (cpu_req_i || dbg_req_i)) begin
         pick_dbg = dbg_req_i && (!cpu_req_i || (starve == STARVE_MAX));
         if (pick_dbg)       starve = 0;
         else if (dbg_req_i) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
         e.dbg   = pick_dbg;
         e.we    = pick_dbg ? dbg_we_i : cpu_we_i;
         e.addr  = pick_dbg ? dbg_addr_i : cpu_addr_i;
         e.wdata = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
         e.rdata = '0;
         e.issue = cyc + 1;
         e.done  = cyc + 2 + MEM_LAT;
         free_cyc = cyc + 3 + MEM_LAT;
         if (e.we) ref_mem[e.addr[5:2]] = e.wdata;
         else      e.rdata = ref_mem[e.addr[5:2]];
         exp_q.push_back(e);
      end
      rst_prev = !rst_i;
   end

   // Requester behaviour: raise, hold until own pulse, occasionally abandon or wiggle operands
   bit cpu_act = 1'b0, dbg_act = 1'b0;
   int p_raise = 4;
   bit allow_drop = 1'b1;

   initial begin
      rst_i = 1'b0;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
      dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
      mem_rdata_i = '0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
         dev_mem[i] = ref_mem[i];
      end
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b1;

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk_i);
         #1;
         p_raise    = (i < 600) ? 4 : (i < 1000) ? 1 : 3;
         allow_drop = (i < 600) || (i >= 1000);
         rst_i      = (i >= 1000 && i < 1480 && ($urandom % 40) == 0) ? 1'b0 : 1'b1;

         if (cpu_act) begin
            if (cpu_done_o) begin cpu_req_i = 1'b0; cpu_act = 1'b0; end
            else if (allow_drop && ($urandom % 32) == 0) begin cpu_req_i = 1'b0; cpu_act = 1'b0; end
            else if (($urandom % 8) == 0) cpu_wdata_i = $urandom;
         end else if (($urandom % p_raise) == 0) begin
            cpu_act     = 1'b1;
            cpu_req_i   = 1'b1;
            cpu_we_i    = 1'($urandom);
            cpu_addr_i  = {26'd0, 4'($urandom), 2'b00};
            cpu_wdata_i = $urandom;
         end

         if (dbg_act) begin
            if (dbg_valid_o) begin dbg_req_i = 1'b0; dbg_act = 1'b0; end
            else if (allow_drop && ($urandom % 32) == 0) begin dbg_req_i = 1'b0; dbg_act = 1'b0; end
            else if (($urandom % 8) == 0) dbg_addr_i = {26'd0, 4'($urandom), 2'b00};
         end else if (($urandom % p_raise) == 0) begin
            dbg_act     = 1'b1;
            dbg_req_i   = 1'b1;
            dbg_we_i    = 1'($urandom);
            dbg_addr_i  = {26'd0, 4'($urandom), 2'b00};
            dbg_wdata_i = $urandom;
         end
      end

      cpu_req_i = 1'b0;
      dbg_req_i = 1'b0;
      repeat (20) @(posedge clk_i);
      @(negedge clk_i);
      chk32("drain_empty", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
